alu_muldiv: RTL and testbench

//  Parametrised execute-stage ALU with an iterative multiply/divide unit.
//  - Single-cycle ops: registered result, 1-cycle latency.
//  - MULTU/DIVU (and optionally MULT/DIV): multi-cycle, with valid/ready on both sides.
//  - Drives portOut/portHi (lo/hi pair) and neg/zero/overflow flags; sits between decode/issue and writeback.

---
 rtl/cpu_types_pkg.sv | 49 ++++
 rtl/alu_muldiv_iter_core.sv | 48 ++++
 rtl/alu_muldiv.sv | 194 +++++++++++++++++++
 tb/tb_alu_muldiv.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU execute-stage types: ALU opcodes, mul/div FSM states and opcode classifiers.
// Optional feature macro: ALU_SIGNED_MULDIV_EN enables the signed MULT/DIV opcodes.
package cpu_types_pkg;

  typedef enum logic [4:0] {
    ALU_SLL   = 5'd0,
    ALU_SRL   = 5'd1,
    ALU_SRA   = 5'd2,
    ALU_ADD   = 5'd3,
    ALU_SUB   = 5'd4,
    ALU_AND   = 5'd5,
    ALU_OR    = 5'd6,
    ALU_XOR   = 5'd7,
    ALU_NOR   = 5'd8,
    ALU_SLT   = 5'd9,
    ALU_SLTU  = 5'd10,
    ALU_MULTU = 5'd11,
    ALU_DIVU  = 5'd12,
    ALU_MULT  = 5'd13,
    ALU_DIV   = 5'd14
  } aluop_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } muldiv_state_t;

  // Without the signed feature, MULT/DIV fall through as undefined single-cycle ops.
  function automatic logic is_muldiv(input aluop_t op);
`ifdef ALU_SIGNED_MULDIV_EN
    return (op == ALU_MULTU) || (op == ALU_DIVU) || (op == ALU_MULT) || (op == ALU_DIV);
`else
    return (op == ALU_MULTU) || (op == ALU_DIVU);
`endif
  endfunction

  function automatic logic is_signed_md(input aluop_t op);
`ifdef ALU_SIGNED_MULDIV_EN
    return (op == ALU_MULT) || (op == ALU_DIV);
`else
    return (op == ALU_MULT) && 1'b0;
`endif
  endfunction

  function automatic logic is_div(input aluop_t op);
    return (op == ALU_DIVU) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter_core.sv
// Combinational mul/div step logic: BITS_PER_CYCLE shift-add or restoring-divide steps per call.
// {hi,lo} is the product accumulator (mul) or remainder/quotient pair (div).
module alu_iter_core #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] l;
  logic [WIDTH:0]   t;

  // Unrolled step chain; the divisor of zero naturally leaves the dividend in hi.
  always_comb begin
    h = hi_in;
    l = lo_in;
    t = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (op_div) begin
        t = {h, l[WIDTH-1]};
        l = {l[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, operand}) begin
          t    = t - {1'b0, operand};
          l[0] = 1'b1;
        end else begin
          l[0] = 1'b0;
        end
        h = t[WIDTH-1:0];
      end else begin
        if (l[0]) begin
          t = {1'b0, h} + {1'b0, operand};
        end else begin
          t = {1'b0, h};
        end
        {h, l} = {t, l[WIDTH-1:1]};
      end
    end
    hi_out = h;
    lo_out = l;
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative mul/div unit with valid/ready.
// Optional feature macro: ALU_SIGNED_MULDIV_EN (signed MULT/DIV via magnitude conversion).
module alu_muldiv
  import cpu_types_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  aluop_t           aluop,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] portOut,
  output logic [WIDTH-1:0] portHi,
  output logic             neg,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(WIDTH);

  muldiv_state_t    state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_acc, lo_acc, opnd, a_orig;
  logic             div_op, res_neg, rem_neg, div_zero, min_ovf;

  logic [WIDTH-1:0]   sum, diff, sc_res, a_mag, b_mag, step_hi, step_lo, fin_lo, fin_hi;
  logic [2*WIDTH-1:0] prod;
  logic [SW-1:0]      shamt;
  logic               sc_ovf, signed_op, a_neg, b_neg, md_op, start_md, start_sc, last_step;
  logic               fin_ovf;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign md_op     = is_muldiv(aluop);
  assign start_md  = in_valid && in_ready && md_op;
  assign start_sc  = in_valid && in_ready && !md_op;
  assign last_step = (state == CALC) && (count == CW'(1));
  assign signed_op = is_signed_md(aluop);
  assign a_neg     = signed_op && portA[WIDTH-1];
  assign b_neg     = signed_op && portB[WIDTH-1];
  assign a_mag     = a_neg ? -portA : portA;
  assign b_mag     = b_neg ? -portB : portB;
  assign shamt     = portB[SW-1:0];
  assign sum       = portA + portB;
  assign diff      = portA - portB;

  // Single-cycle result and signed add/sub overflow.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (aluop)
      ALU_SLL:  sc_res = portA << shamt;
      ALU_SRL:  sc_res = portA >> shamt;
      ALU_SRA:  sc_res = $unsigned($signed(portA) >>> shamt);
      ALU_ADD: begin
        sc_res = sum;
        sc_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) && (sum[WIDTH-1] != portA[WIDTH-1]);
      end
      ALU_SUB: begin
        sc_res = diff;
        sc_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) && (diff[WIDTH-1] != portA[WIDTH-1]);
      end
      ALU_AND:  sc_res = portA & portB;
      ALU_OR:   sc_res = portA | portB;
      ALU_XOR:  sc_res = portA ^ portB;
      ALU_NOR:  sc_res = ~(portA | portB);
      ALU_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(portA) < $signed(portB))};
      ALU_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (portA < portB)};
      default:  sc_res = '0;
    endcase
  end

  alu_iter_core #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .op_div  (div_op),
    .hi_in   (hi_acc),
    .lo_in   (lo_acc),
    .operand (opnd),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  // Restore signs from the magnitude result; divide-by-zero overrides everything.
  always_comb begin
    prod    = res_neg ? -{step_hi, step_lo} : {step_hi, step_lo};
    fin_lo  = prod[WIDTH-1:0];
    fin_hi  = prod[2*WIDTH-1:WIDTH];
    fin_ovf = 1'b0;
    if (div_op) begin
      if (div_zero) begin
        fin_lo  = '1;
        fin_hi  = a_orig;
        fin_ovf = 1'b1;
      end else begin
        fin_lo  = res_neg ? -step_lo : step_lo;
        fin_hi  = rem_neg ? -step_hi : step_hi;
        fin_ovf = min_ovf;
      end
    end else begin
      fin_ovf = 1'b0;
    end
  end

  // Mul/div FSM, iteration registers and the held output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      count     <= '0;
      hi_acc    <= '0;
      lo_acc    <= '0;
      opnd      <= '0;
      a_orig    <= '0;
      div_op    <= 1'b0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      div_zero  <= 1'b0;
      min_ovf   <= 1'b0;
      out_valid <= 1'b0;
      portOut   <= '0;
      portHi    <= '0;
      neg       <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      count     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_md) begin
            state    <= CALC;
            busy     <= 1'b1;
            count    <= CW'(N);
            hi_acc   <= '0;
            lo_acc   <= is_div(aluop) ? a_mag : b_mag;
            opnd     <= is_div(aluop) ? b_mag : a_mag;
            div_op   <= is_div(aluop);
            res_neg  <= a_neg ^ b_neg;
            rem_neg  <= a_neg;
            div_zero <= (portB == '0);
            min_ovf  <= signed_op && (portA == {1'b1, {(WIDTH-1){1'b0}}}) && (portB == '1);
            a_orig   <= portA;
          end
        end
        CALC: begin
          hi_acc <= step_hi;
          lo_acc <= step_lo;
          count  <= count - CW'(1);
          if (last_step) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (start_sc) begin
        portOut   <= sc_res;
        portHi    <= '0;
        neg       <= sc_res[WIDTH-1];
        zero      <= (sc_res == '0);
        overflow  <= sc_ovf;
        out_valid <= 1'b1;
      end else if (last_step) begin
        portOut   <= fin_lo;
        portHi    <= fin_hi;
        neg       <= fin_lo[WIDTH-1];
        zero      <= (fin_lo == '0);
        overflow  <= fin_ovf;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized scoreboard bench for alu_muldiv (WIDTH=32, BITS_PER_CYCLE=1).
// Signed expectations follow ALU_SIGNED_MULDIV_EN when it is defined.
module tb_alu_muldiv;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  aluop_t      aluop = ALU_ADD;
  logic [31:0] portA = 32'd0;
  logic [31:0] portB = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] portOut, portHi;
  logic        neg, zero, overflow, busy;

  alu_muldiv #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
    .portA(portA), .portB(portB), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .portOut(portOut), .portHi(portHi), .neg(neg),
    .zero(zero), .overflow(overflow), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   hold_ready = 1'b0;
  bit   stall_prev = 1'b0;
  logic [65:0] stall_snap;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on wide integers, straight from the op definitions.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint s;
    logic [63:0] p;
    int     sh;
    e.lo = 32'd0; e.hi = 32'd0; e.ovf = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      ALU_SLL:  e.lo = a << sh;
      ALU_SRL:  e.lo = a >> sh;
      ALU_SRA:  e.lo = 32'($signed(a) >>> sh);
      ALU_ADD: begin
        e.lo = a + b;
        s = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_SUB: begin
        e.lo = a - b;
        s = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      ALU_AND:  e.lo = a & b;
      ALU_OR:   e.lo = a | b;
      ALU_XOR:  e.lo = a ^ b;
      ALU_NOR:  e.lo = ~(a | b);
      ALU_SLT:  e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: e.lo = (a < b) ? 32'd1 : 32'd0;
      ALU_MULTU: begin
        p = 64'(a) * 64'(b);
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      ALU_DIVU: begin
        if (b == 32'd0) begin e.lo = 32'hFFFFFFFF; e.hi = a; e.ovf = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
`ifdef ALU_SIGNED_MULDIV_EN
      ALU_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      ALU_DIV: begin
        if (b == 32'd0) begin e.lo = 32'hFFFFFFFF; e.hi = a; e.ovf = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          e.lo = 32'h80000000; e.hi = 32'd0; e.ovf = 1'b1;
        end else begin
          e.lo = 32'($signed(a) / $signed(b));
          e.hi = 32'($signed(a) % $signed(b));
        end
      end
`endif
      default: e.lo = 32'd0;
    endcase
    return e;
  endfunction

  // Monitor: picks out_ready, checks stall stability, pops and compares on handshake.
  always @(negedge CLK) begin
    exp_t e;
    if (stall_prev)
      check("stall_hold", {out_valid, 1'b0, portOut, portHi}, stall_snap);
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    stall_prev = out_valid && !out_ready && !RST;
    stall_snap = {1'b1, 1'b0, portOut, portHi};
    if (out_valid && out_ready && !RST) begin
      if (q.size() == 0) begin
        check("unexpected_result", {34'd0, portOut}, 66'd0 - 66'd1);
      end else begin
        e = q.pop_front();
        check("portOut", {34'd0, portOut}, {34'd0, e.lo});
        check("portHi", {34'd0, portHi}, {34'd0, e.hi});
        check("flags_nzo", {63'd0, neg, zero, overflow},
              {63'd0, e.lo[31], (e.lo == 32'd0), e.ovf});
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int tries = 0;
    @(negedge CLK);
    in_valid = 1'b1; aluop = aluop_t'(op); portA = a; portB = b;
    #1;
    while (!in_ready && tries < 200) begin
      @(negedge CLK); #1; tries++;
    end
    if (!in_ready) begin
      check("issue_timeout", 66'd0, 66'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    if (push) q.push_back(model(op, a, b));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || out_valid) && t < 500) begin
      @(negedge CLK); t++;
    end
    if (t >= 500) check("drain_timeout", 66'd0, 66'd1);
  endtask

  task automatic check_reset_state(input string name);
    check(name, {58'd0, out_valid, busy, neg, zero, overflow, in_ready, (portOut == 32'd0),
                 (portHi == 32'd0)}, {58'd0, 8'b0000_0111});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h80000000;
      3: return 32'hFFFFFFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busy_cnt, lat, seen;
    logic [4:0] op;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_state("reset_state");

    issue(ALU_ADD, 32'h7FFFFFFF, 32'd1, 1'b1);
    issue(ALU_SUB, 32'h80000000, 32'd1, 1'b1);
    issue(ALU_SUB, 32'd5, 32'd5, 1'b1);
    issue(ALU_SRA, 32'h80000010, 32'd36, 1'b1);
    issue(ALU_SLT, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'd0, 1'b1);
    issue(5'd20, 32'd7, 32'd9, 1'b1);
    drain();

    // Multiply latency and busy window.
    issue(ALU_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1);
    busy_cnt = 0; lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (busy) busy_cnt++;
      if (out_valid) begin lat = k; break; end
    end
    check("mul_latency", 66'(lat), 66'd33);
    check("mul_busy_cycles", 66'(busy_cnt), 66'd32);
    drain();

    issue(ALU_DIVU, 32'd100, 32'd7, 1'b1);
    issue(ALU_DIVU, 32'd9, 32'd0, 1'b1);
    drain();

    // Consumer stall: result held, no new acceptance.
    hold_ready = 1'b1;
    issue(ALU_ADD, 32'd3, 32'd4, 1'b1);
    repeat (4) begin
      @(negedge CLK); #1;
      check("stall_in_ready", {65'd0, in_ready}, 66'd0);
    end
    hold_ready = 1'b0;
    drain();

    // Flush in cycle 10 of a divide: result must never appear.
    issue(ALU_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge CLK);
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", {65'd0, in_ready}, 66'd0);
    @(negedge CLK);
    flush = 1'b0;
    #1;
    check("after_flush", {64'd0, in_ready, out_valid}, 66'b10);
    seen = 0;
    repeat (40) begin @(negedge CLK); if (out_valid) seen++; end
    check("flush_no_result", 66'(seen), 66'd0);

    // Reset mid-calculation.
    issue(ALU_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_state("reset_mid_calc");
    seen = 0;
    repeat (40) begin @(negedge CLK); if (out_valid) seen++; end
    check("reset_no_result", 66'(seen), 66'd0);

`ifdef ALU_SIGNED_MULDIV_EN
    issue(ALU_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    issue(ALU_MULT, 32'hFFFFFFFD, 32'd4, 1'b1);
    issue(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    issue(ALU_DIV, 32'hFFFFFFF7, 32'd0, 1'b1);
    drain();
`else
    issue(ALU_MULT, 32'd6, 32'd7, 1'b1);
    issue(ALU_DIV, 32'd6, 32'd3, 1'b1);
    drain();
`endif

    for (int i = 0; i < 300; i++) begin
      op = 5'($urandom_range(0, 16));
      if (op > 5'd14) op = 5'($urandom_range(15, 31));
      issue(op, pick(), pick(), 1'b1);
    end
    drain();
    check("queue_empty", 66'(q.size()), 66'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
